// File: rtl/vend_ctrl.sv
// vend_ctrl - coin vending machine transaction controller.
//
// Accumulates credit from single-cycle coin pulses, requests a dispense via a
// vend_req/vend_ack handshake, then pays change (or a cancel refund) one coin
// at a time through the ej_n/ej_d + ej_done handshake. Tracks nickel and dime
// tube inventory and drives the exact-change-only lamp. A handshake that
// stalls for TMO cycles, or a nickel owed with an empty nickel tube, parks the
// controller in FAULT until reset.
//
// Ports:
//   clk                 system clock, rising edge
//   rst_                asynchronous active-low reset
//   n, d, q             coin-accepted pulses (5, 10, 25 cents)
//   cancel              coin-return button pulse
//   vend_ack            motor driver done
//   ej_done             ejector finished the current coin
//   refill_n, refill_d  service refill pulses, one coin per cycle high
//   vend_req            dispense request (registered)
//   ej_n, ej_d          eject one nickel / dime (registered)
//   coin_rej            one-cycle pulse, coin routed to reject chute
//   credit              current credit in cents (registered)
//   exact_only          exact-change-only lamp (combinational from inventory)
//   busy                controller not idle (combinational from state)
//   fault               sticky handshake / inventory fault (registered)
module vend_ctrl #(
    parameter int PRICE = 25,
    parameter int CNT_W = 6,
    parameter int TMO   = 255
) (
    input  logic       clk,
    input  logic       rst_,
    input  logic       n,
    input  logic       d,
    input  logic       q,
    input  logic       cancel,
    input  logic       vend_ack,
    input  logic       ej_done,
    input  logic       refill_n,
    input  logic       refill_d,
    output logic       vend_req,
    output logic       ej_n,
    output logic       ej_d,
    output logic       coin_rej,
    output logic [6:0] credit,
    output logic       exact_only,
    output logic       busy,
    output logic       fault
);
    localparam int               TMO_W    = $clog2(TMO + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO - 1);
    localparam int               CW2      = CNT_W + 2;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [7:0]       PRICE_8  = 8'(PRICE);

    typedef enum logic [1:0] {ST_IDLE, ST_VEND, ST_CHANGE, ST_FAULT} state_t;

    state_t           state_reg;
    logic [6:0]       credit_reg;
    logic [6:0]       chg_reg;
    logic [TMO_W-1:0] tmo_reg;
    logic             vend_req_reg;
    logic             ej_n_reg;
    logic             ej_d_reg;
    logic             coin_rej_reg;
    logic             fault_reg;
    logic             gap_reg;     // forces one idle cycle between ejects

    // Tube inventory: index 0 = nickels, 1 = dimes
    logic [CNT_W-1:0] tube_cnt [2];
    logic [CNT_W-1:0] nick_cnt;
    logic [CNT_W-1:0] dime_cnt;
    logic [1:0]       inc_coin;
    logic [1:0]       inc_refill;
    logic [1:0]       dec_eject;

    logic [1:0]       coin_num;
    logic             coin_any;
    logic [6:0]       coin_val;
    logic [7:0]       sum_all;
    logic [7:0]       sum_acc;
    logic             over_exact;
    logic             coin_acc;
    logic             coin_rej_next;
    logic [CW2-1:0]   inv_units;
    logic [6:0]       chg_step;

    assign nick_cnt = tube_cnt[0];
    assign dime_cnt = tube_cnt[1];

    // Inventory expressed in nickel units: 5n + 10d < 20  <=>  n + 2d < 4
    assign inv_units  = {2'b00, nick_cnt} + {1'b0, dime_cnt, 1'b0};
    assign exact_only = (nick_cnt == '0) || (inv_units < CW2'(4));

    // Coin priority: only the highest-valued pulse competes for credit
    assign coin_num = {1'b0, n} + {1'b0, d} + {1'b0, q};
    assign coin_any = n | d | q;
    assign coin_val = q ? 7'd25 : (d ? 7'd10 : (n ? 7'd5 : 7'd0));
    assign sum_all  = {1'b0, credit_reg} + {1'b0, coin_val};

    // With the lamp lit we cannot promise change, so refuse any overpay
    assign over_exact    = exact_only && (sum_all > PRICE_8);
    assign coin_acc      = coin_any && (state_reg == ST_IDLE) && !over_exact;
    assign sum_acc       = coin_acc ? sum_all : {1'b0, credit_reg};
    // Losing coins and the refused winner share a single reject pulse
    assign coin_rej_next = (coin_num >= 2'd2) || (coin_any && !coin_acc);

    assign inc_coin[0]  = coin_acc && n && !d && !q;
    assign inc_coin[1]  = coin_acc && d && !q;
    assign inc_refill   = {refill_d, refill_n};
    assign dec_eject[0] = (state_reg == ST_CHANGE) && ej_n_reg && ej_done;
    assign dec_eject[1] = (state_reg == ST_CHANGE) && ej_d_reg && ej_done;

    assign chg_step = ej_d_reg ? 7'd10 : 7'd5;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_tube
            logic [CNT_W-1:0] cnt_reg;
            logic [CW2-1:0]   cnt_next;

            // A decrement is only ever issued for a non-empty tube, so the
            // sum cannot underflow; refills and coin credit saturate.
            assign cnt_next = {2'b00, cnt_reg} + CW2'(inc_coin[gi])
                            + CW2'(inc_refill[gi]) - CW2'(dec_eject[gi]);

            always_ff @(posedge clk or negedge rst_) begin
                if (!rst_) begin
                    cnt_reg <= '0;
                end else if (cnt_next > {2'b00, CNT_MAX}) begin
                    cnt_reg <= CNT_MAX;
                end else begin
                    cnt_reg <= cnt_next[CNT_W-1:0];
                end
            end

            assign tube_cnt[gi] = cnt_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_reg    <= ST_IDLE;
            credit_reg   <= '0;
            chg_reg      <= '0;
            tmo_reg      <= '0;
            vend_req_reg <= 1'b0;
            ej_n_reg     <= 1'b0;
            ej_d_reg     <= 1'b0;
            coin_rej_reg <= 1'b0;
            fault_reg    <= 1'b0;
            gap_reg      <= 1'b0;
        end else begin
            coin_rej_reg <= coin_rej_next;
            case (state_reg)
                ST_IDLE: begin
                    if (cancel && (sum_acc != 8'd0)) begin
                        chg_reg    <= sum_acc[6:0];
                        credit_reg <= '0;
                        tmo_reg    <= '0;
                        gap_reg    <= 1'b0;
                        state_reg  <= ST_CHANGE;
                    end else if (sum_acc >= PRICE_8) begin
                        chg_reg      <= 7'(sum_acc - PRICE_8);
                        credit_reg   <= '0;
                        vend_req_reg <= 1'b1;
                        tmo_reg      <= '0;
                        state_reg    <= ST_VEND;
                    end else begin
                        credit_reg <= sum_acc[6:0];
                    end
                end
                ST_VEND: begin
                    if (vend_ack) begin
                        vend_req_reg <= 1'b0;
                        tmo_reg      <= '0;
                        gap_reg      <= 1'b0;
                        state_reg    <= (chg_reg != '0) ? ST_CHANGE : ST_IDLE;
                    end else if (tmo_reg == TMO_LAST) begin
                        vend_req_reg <= 1'b0;
                        fault_reg    <= 1'b1;
                        state_reg    <= ST_FAULT;
                    end else begin
                        tmo_reg <= tmo_reg + 1'b1;
                    end
                end
                ST_CHANGE: begin
                    if (ej_n_reg || ej_d_reg) begin
                        if (ej_done) begin
                            ej_n_reg <= 1'b0;
                            ej_d_reg <= 1'b0;
                            gap_reg  <= 1'b1;
                            chg_reg  <= chg_reg - chg_step;
                            if (chg_reg == chg_step) begin
                                state_reg <= ST_IDLE;
                            end
                        end else if (tmo_reg == TMO_LAST) begin
                            ej_n_reg  <= 1'b0;
                            ej_d_reg  <= 1'b0;
                            fault_reg <= 1'b1;
                            state_reg <= ST_FAULT;
                        end else begin
                            tmo_reg <= tmo_reg + 1'b1;
                        end
                    end else if (gap_reg) begin
                        gap_reg <= 1'b0;
                    end else if ((chg_reg >= 7'd10) && (dime_cnt != '0)) begin
                        ej_d_reg <= 1'b1;
                        tmo_reg  <= '0;
                    end else if (nick_cnt != '0) begin
                        ej_n_reg <= 1'b1;
                        tmo_reg  <= '0;
                    end else begin
                        // Owe a nickel but the tube is empty
                        fault_reg <= 1'b1;
                        state_reg <= ST_FAULT;
                    end
                end
                default: begin
                    // FAULT: handshakes held low, only reset leaves
                    vend_req_reg <= 1'b0;
                    ej_n_reg     <= 1'b0;
                    ej_d_reg     <= 1'b0;
                    fault_reg    <= 1'b1;
                end
            endcase
        end
    end

    assign vend_req = vend_req_reg;
    assign ej_n     = ej_n_reg;
    assign ej_d     = ej_d_reg;
    assign coin_rej = coin_rej_reg;
    assign credit   = credit_reg;
    assign fault    = fault_reg;
    assign busy     = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_vend_ctrl.sv
// tb_vend_ctrl - self-checking bench for vend_ctrl.
//
// The bench plays coin acceptor, motor driver and ejector. A transaction-level
// model (credit in cents, tube coin counts, change owed) predicts every
// observable result; directed scenarios are followed by a random session.
module tb_vend_ctrl;
    localparam int PRICE = 25;
    localparam int CNT_W = 6;
    localparam int TMO   = 255;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic       clk = 1'b0;
    logic       rst_ = 1'b0;
    logic       n = 1'b0, d = 1'b0, q = 1'b0, cancel = 1'b0;
    logic       vend_ack = 1'b0, ej_done = 1'b0;
    logic       refill_n = 1'b0, refill_d = 1'b0;
    logic       vend_req, ej_n, ej_d, coin_rej, exact_only, busy, fault;
    logic [6:0] credit;

    int n_total = 0;
    int n_bad   = 0;

    // Model state
    int m_credit = 0;
    int m_nick   = 0;
    int m_dime   = 0;

    always #5 clk = ~clk;

    vend_ctrl #(.PRICE(PRICE), .CNT_W(CNT_W), .TMO(TMO)) dut (
        .clk(clk), .rst_(rst_),
        .n(n), .d(d), .q(q), .cancel(cancel),
        .vend_ack(vend_ack), .ej_done(ej_done),
        .refill_n(refill_n), .refill_d(refill_d),
        .vend_req(vend_req), .ej_n(ej_n), .ej_d(ej_d), .coin_rej(coin_rej),
        .credit(credit), .exact_only(exact_only), .busy(busy), .fault(fault)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int m_exact();
        return ((m_nick == 0) || (5 * m_nick + 10 * m_dime < 20)) ? 1 : 0;
    endfunction

    function automatic int sat_inc(input int v);
        return (v < CMAX) ? v + 1 : CMAX;
    endfunction

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_ = 1'b0;
        #3;
        chk("rst_credit", credit, 0);
        chk("rst_vend_req", vend_req, 0);
        chk("rst_ej", ej_n | ej_d, 0);
        chk("rst_coin_rej", coin_rej, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fault", fault, 0);
        chk("rst_exact", exact_only, 1);
        step();
        step();
        rst_ = 1'b1;
        m_credit = 0;
        m_nick   = 0;
        m_dime   = 0;
        step();
        $display("txn reset");
    endtask

    task automatic refill(input int nn, input int dd);
        int k;
        k = (nn > dd) ? nn : dd;
        for (int i = 0; i < k; i++) begin
            refill_n = (i < nn);
            refill_d = (i < dd);
            step();
            if (i < nn) m_nick = sat_inc(m_nick);
            if (i < dd) m_dime = sat_inc(m_dime);
        end
        refill_n = 1'b0;
        refill_d = 1'b0;
        chk("refill_exact", exact_only, m_exact());
        $display("txn refill +n=%0d +d=%0d -> nick=%0d dime=%0d", nn, dd, m_nick, m_dime);
    endtask

    // Pay out chg; first eject one cycle after entry, later ones two cycles
    // after the previous ej_done.
    task automatic do_change(input int chg_in);
        int  chg;
        int  gap;
        int  w;
        int  hold;
        bit  want_d;
        chg = chg_in;
        gap = 1;
        while (chg > 0) begin
            want_d = (chg >= 10) && (m_dime > 0);
            if (!want_d && (m_nick == 0)) begin
                for (int i = 0; i < gap; i++) step();
                chk("chg_fault", fault, 1);
                chk("chg_fault_ej", ej_n | ej_d, 0);
                $display("txn change fault, owed=%0d", chg);
                do_reset();
                return;
            end
            w = 0;
            while (!(ej_n || ej_d) && (w < 8)) begin
                step();
                w++;
            end
            chk("ej_gap", w, gap);
            chk("ej_d_sel", ej_d, want_d);
            chk("ej_n_sel", ej_n, !want_d);
            hold = $urandom_range(1, 3);
            for (int i = 0; i < hold; i++) begin
                if (i == 0) n = 1'b1;
                step();
                if (i == 0) begin
                    n = 1'b0;
                    chk("chg_coin_rej", coin_rej, 1);
                end
                chk("ej_hold", ej_n | ej_d, 1);
            end
            ej_done = 1'b1;
            step();
            ej_done = 1'b0;
            chk("ej_release", ej_n | ej_d, 0);
            chg = chg - (want_d ? 10 : 5);
            if (want_d) m_dime--;
            else        m_nick--;
            $display("txn eject %s, owed=%0d", want_d ? "dime" : "nickel", chg);
            gap = 2;
        end
        chk("chg_idle", busy, 0);
        chk("chg_exact", exact_only, m_exact());
    endtask

    task automatic do_vend(input int chg);
        int dly;
        dly = $urandom_range(1, 4);
        for (int i = 0; i < dly; i++) begin
            if (i == 0) d = 1'b1;
            step();
            if (i == 0) begin
                d = 1'b0;
                chk("vend_coin_rej", coin_rej, 1);
            end
            chk("vend_hold", vend_req, 1);
        end
        vend_ack = 1'b1;
        step();
        vend_ack = 1'b0;
        chk("vend_drop", vend_req, 0);
        chk("vend_busy", busy, (chg > 0) ? 1 : 0);
        $display("txn vend, change=%0d", chg);
        if (chg > 0) do_change(chg);
    endtask

    task automatic insert(input bit cn, input bit cd, input bit cq, input bit cc);
        int nc, val, sum;
        bit acc, rej;
        nc  = int'(cn) + int'(cd) + int'(cq);
        val = cq ? 25 : (cd ? 10 : (cn ? 5 : 0));
        acc = (nc > 0) && !((m_exact() == 1) && (m_credit + val > PRICE));
        rej = (nc >= 2) || ((nc > 0) && !acc);
        sum = m_credit + (acc ? val : 0);
        n = cn; d = cd; q = cq; cancel = cc;
        step();
        n = 1'b0; d = 1'b0; q = 1'b0; cancel = 1'b0;
        if (acc && !cq) begin
            if (cd) m_dime = sat_inc(m_dime);
            else    m_nick = sat_inc(m_nick);
        end
        $display("txn coin n=%0d d=%0d q=%0d cancel=%0d accepted=%0d sum=%0d",
                 cn, cd, cq, cc, acc, sum);
        chk("coin_rej", coin_rej, rej);
        if (cc && (sum > 0)) begin
            m_credit = 0;
            chk("cancel_credit", credit, 0);
            chk("cancel_vend_req", vend_req, 0);
            chk("cancel_busy", busy, 1);
            do_change(sum);
        end else if (sum >= PRICE) begin
            m_credit = 0;
            chk("vend_credit", credit, 0);
            chk("vend_req", vend_req, 1);
            do_vend(sum - PRICE);
        end else begin
            m_credit = sum;
            chk("credit", credit, sum);
            chk("idle_busy", busy, 0);
            chk("idle_exact", exact_only, m_exact());
        end
    endtask

    task automatic tmo_test();
        q = 1'b1;
        step();
        q = 1'b0;
        chk("tmo_vend_req", vend_req, 1);
        for (int i = 1; i < TMO; i++) step();
        chk("tmo_pre_fault", fault, 0);
        chk("tmo_pre_vend_req", vend_req, 1);
        step();
        chk("tmo_fault", fault, 1);
        chk("tmo_vend_req_low", vend_req, 0);
        chk("tmo_busy", busy, 1);
        n = 1'b1;
        step();
        n = 1'b0;
        chk("fault_coin_rej", coin_rej, 1);
        $display("txn vend timeout");
        do_reset();
    endtask

    initial begin
        bit [3:0] r;
        step();
        do_reset();

        // Five nickels with 4n/2d stocked: credit 5..20, then vend, no change
        refill(4, 2);
        for (int i = 0; i < 5; i++) insert(1'b1, 1'b0, 1'b0, 1'b0);

        // d then q: vend with one dime of change
        do_reset();
        refill(4, 2);
        insert(1'b0, 1'b1, 1'b0, 1'b0);
        insert(1'b0, 1'b0, 1'b1, 1'b0);

        // Exact-change lamp refuses an overpaying quarter; then refund
        do_reset();
        insert(1'b0, 1'b1, 1'b0, 1'b0);
        insert(1'b0, 1'b1, 1'b0, 1'b0);
        insert(1'b0, 1'b0, 1'b1, 1'b0);
        insert(1'b0, 1'b0, 1'b0, 1'b1);

        // Three coins at once: quarter wins, one reject pulse
        do_reset();
        refill(4, 2);
        insert(1'b1, 1'b1, 1'b1, 1'b0);

        // Credit 15, cancel: dime then nickel; cancel at zero credit ignored
        do_reset();
        refill(4, 2);
        insert(1'b1, 1'b0, 1'b0, 1'b0);
        insert(1'b0, 1'b1, 1'b0, 1'b0);
        insert(1'b0, 1'b0, 1'b0, 1'b1);
        insert(1'b0, 1'b0, 1'b0, 1'b1);

        // Refill past saturation keeps the lamp off
        do_reset();
        refill(CMAX + 3, 0);

        // Vend handshake timeout
        do_reset();
        tmo_test();

        // Random session
        refill(3, 2);
        for (int t = 0; t < 150; t++) begin
            case ($urandom_range(0, 9))
                0, 1: refill($urandom_range(0, 3), $urandom_range(0, 3));
                2:    insert(1'b0, 1'b0, 1'b0, 1'b1);
                default: begin
                    r = 4'($urandom_range(0, 15));
                    insert(r[0], r[1], r[2] & r[3], ($urandom_range(0, 7) == 0));
                end
            endcase
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
